// File: rtl/show_seq_pkg.sv
// Shared types and defaults for the display sequencer.
// Holds the sequencer state encoding, the index width and default sizing.
package show_seq_pkg;

    localparam int IDX_W        = 4;
    localparam int N_ITEMS_DEF  = 13;
    localparam int TICK_DIV_DEF = 50_000_000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } show_state_t;

endpackage

// File: rtl/show_tick_div.sv
// Auto-step divider: counts 0..TICK_DIV-1 and emits a registered one-cycle tick
// after the terminal count. hold freezes the count, clear forces it to zero.
module show_tick_div #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic hold,
    input  logic clear,
    output logic tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (clear) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (hold) begin
            // Count is kept so a released hold resumes the partial period.
            tick <= 1'b0;
        end else begin
            tick <= (cnt == LAST);
            cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/show_seq_ctrl.sv
// Display sequencer: steps show_idx on tick or step_req and fetches the matching
// word over the debug read port so shown index and shown data never disagree.
module show_seq_ctrl
    import show_seq_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEF,
    parameter int N_ITEMS  = N_ITEMS_DEF,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              mode_auto,
    input  logic              step_req,
    input  logic              hold,
    output logic              rd_req,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic              rd_gnt,
    input  logic              rd_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic [IDX_W-1:0]  show_idx,
    output logic [DATA_W-1:0] show_data,
    output logic              show_valid,
    output show_state_t       dbg_state
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ITEMS - 1);

    show_state_t       state, state_nxt;
    logic [IDX_W-1:0]  idx_nxt;
    logic [DATA_W-1:0] data_nxt;
    logic              valid_nxt;
    logic              fetch_pend, fetch_pend_nxt;
    logic              adv_pend, adv_pend_nxt;
    logic              tick;
    logic              advance;

    show_tick_div #(.TICK_DIV(TICK_DIV)) u_tick_div (
        .clk   (clk),
        .rst_n (rst_n),
        .hold  (hold),
        .clear (!mode_auto),
        .tick  (tick)
    );

    assign advance = ((tick & mode_auto) | step_req) & ~hold;

    // Debug port: rd_req stays high through REQ until rd_gnt is sampled; the word
    // then arrives as a one-cycle rd_valid in a later cycle and is taken only in WAIT.
    assign rd_req    = (state == REQ);
    assign rd_addr   = ADDR_W'(show_idx);
    assign dbg_state = state;

    always_comb begin
        state_nxt      = state;
        idx_nxt        = show_idx;
        data_nxt       = show_data;
        valid_nxt      = show_valid;
        fetch_pend_nxt = fetch_pend;
        adv_pend_nxt   = adv_pend;
        case (state)
            IDLE: begin
                if (adv_pend || advance) begin
                    idx_nxt        = (show_idx == LAST_IDX) ? '0 : show_idx + 1'b1;
                    valid_nxt      = 1'b0;
                    adv_pend_nxt   = 1'b0;
                    fetch_pend_nxt = 1'b0;
                    state_nxt      = REQ;
                end else if (fetch_pend) begin
                    fetch_pend_nxt = 1'b0;
                    state_nxt      = REQ;
                end
            end
            REQ: begin
                if (advance) begin
                    adv_pend_nxt   = 1'b1;
                    fetch_pend_nxt = 1'b1;
                end
                if (rd_gnt) state_nxt = WAIT;
            end
            WAIT: begin
                if (advance) begin
                    adv_pend_nxt   = 1'b1;
                    fetch_pend_nxt = 1'b1;
                end
                if (rd_valid) begin
                    data_nxt  = rd_data;
                    valid_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            show_idx   <= '0;
            show_data  <= '0;
            show_valid <= 1'b0;
            fetch_pend <= 1'b1;
            adv_pend   <= 1'b0;
        end else begin
            state      <= state_nxt;
            show_idx   <= idx_nxt;
            show_data  <= data_nxt;
            show_valid <= valid_nxt;
            fetch_pend <= fetch_pend_nxt;
            adv_pend   <= adv_pend_nxt;
        end
    end

endmodule

// File: tb/tb_show_seq_ctrl.sv
// Bench for show_seq_ctrl: directed scenarios, an event-level model checked every
// cycle, a grant-address scoreboard and literal expectations per scenario.
module tb_show_seq_ctrl;
    import show_seq_pkg::*;

    localparam int TICK_DIV = 4;
    localparam int N_ITEMS  = 13;
    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              mode_auto = 1'b0;
    logic              step_req = 1'b0;
    logic              hold = 1'b0;
    logic              rd_gnt = 1'b0;
    logic              rd_valid = 1'b0;
    logic [DATA_W-1:0] rd_data = '0;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [3:0]        show_idx;
    logic [DATA_W-1:0] show_data;
    logic              show_valid;
    show_state_t       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    show_seq_ctrl #(
        .TICK_DIV (TICK_DIV),
        .N_ITEMS  (N_ITEMS),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode_auto  (mode_auto),
        .step_req   (step_req),
        .hold       (hold),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_gnt     (rd_gnt),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .show_idx   (show_idx),
        .show_data  (show_data),
        .show_valid (show_valid),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] data_for(input logic [ADDR_W-1:0] a);
        return 32'hA5A5_0000 | {16'h0, 3'b0, a, 3'b0, a};
    endfunction

    // ---------------- debug-port responder ----------------
    int                gnt_withhold = 0;
    int                valid_lat    = 1;
    int                withheld     = 0;
    int                vcnt         = 0;
    int                stray_tok    = 0;
    int                stray_seen   = 0;
    logic [ADDR_W-1:0] pend_addr    = '0;
    logic [ADDR_W-1:0] granted_addr = '0;

    always @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_gnt = 1'b0; rd_valid = 1'b0; vcnt = 0; withheld = 0; stray_seen = stray_tok;
        end else begin
            rd_gnt = 1'b0;
            rd_valid = 1'b0;
            if (vcnt > 0) begin
                vcnt--;
                if (vcnt == 0) begin
                    rd_valid = 1'b1;
                    rd_data  = data_for(pend_addr);
                end
            end else if (stray_seen != stray_tok) begin
                stray_seen = stray_tok;
                rd_valid   = 1'b1;
                rd_data    = 32'hDEAD_BEEF;
            end
            if (rd_req) begin
                if (withheld < gnt_withhold) withheld++;
                else begin
                    withheld     = 0;
                    rd_gnt       = 1'b1;
                    pend_addr    = rd_addr;
                    granted_addr = rd_addr;
                    vcnt         = valid_lat;
                end
            end
        end
    end

    // ---------------- behavioural model + scoreboard ----------------
    int                m_acc, m_idx;
    bit                m_tick, m_adv, m_busy, m_granted, m_adv_pend, m_fetch_pend, m_valid;
    logic [31:0]       m_data;
    logic [ADDR_W-1:0] exp_q[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acc = 0; m_tick = 0; m_busy = 0; m_granted = 0; m_adv_pend = 0;
            m_fetch_pend = 1; m_valid = 0; m_idx = 0; m_data = '0;
            exp_q.delete();
        end else begin
            m_adv = ((m_tick && mode_auto) || step_req) && !hold;
            // Every TICK_DIV-th eligible auto cycle yields a tick one cycle later.
            if (!mode_auto) begin
                m_acc = 0; m_tick = 0;
            end else if (hold) begin
                m_tick = 0;
            end else begin
                m_acc++;
                m_tick = (m_acc % TICK_DIV == 0);
            end
            if (!m_busy) begin
                if (m_adv_pend || m_adv || m_fetch_pend) begin
                    if (m_adv_pend || m_adv) begin
                        m_idx   = (m_idx + 1) % N_ITEMS;
                        m_valid = 0;
                    end
                    m_adv_pend = 0; m_fetch_pend = 0; m_busy = 1; m_granted = 0;
                    exp_q.push_back(ADDR_W'(m_idx));
                end
            end else begin
                if (m_adv) begin
                    m_adv_pend = 1; m_fetch_pend = 1;
                end
                if (!m_granted) begin
                    if (rd_gnt) begin
                        m_granted = 1;
                        if (exp_q.size() == 0) check("grant_unexpected", 32'd1, 32'd0);
                        else check("grant_addr", 32'(granted_addr), 32'(exp_q.pop_front()));
                    end
                end else if (rd_valid) begin
                    m_data = data_for(ADDR_W'(m_idx)); m_valid = 1; m_busy = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        check("show_idx",   32'(show_idx),   32'(m_idx));
        check("show_valid", 32'(show_valid), 32'(m_valid));
        check("show_data",  show_data,       m_data);
        check("rd_req",     32'(rd_req),     32'(m_busy && !m_granted));
        check("rd_addr",    32'(rd_addr),    32'(m_idx));
    end

    // ---------------- driver tasks ----------------
    task automatic pulse_step();
        step_req = 1'b1;
        @(negedge clk);
        step_req = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int stable = 0;
        for (int i = 0; i < budget && stable < 2; i++) begin
            @(negedge clk);
            if (dbg_state == IDLE && show_valid && !rd_req) stable++;
            else stable = 0;
        end
        if (stable < 2) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    // ---------------- scenarios ----------------
    initial begin
        int changes, prev, c_rel;
        bit seen;

        repeat (3) @(negedge clk);
        check("rst_idx",   32'(show_idx),   32'd0);
        check("rst_valid", 32'(show_valid), 32'd0);
        check("rst_data",  show_data,       32'd0);
        check("rst_req",   32'(rd_req),     32'd0);
        check("rst_addr",  32'(rd_addr),    32'd0);
        check("rst_state", 32'(dbg_state),  32'(IDLE));
        rst_n = 1'b1;
        wait_idle(20, "s1");
        check("s1_data",  show_data,       32'hA5A5_0000);
        check("s1_valid", 32'(show_valid), 32'd1);
        check("s1_idx",   32'(show_idx),   32'd0);

        // auto mode: 60 cycles, one advance every 4
        mode_auto = 1'b1;
        changes = 0; prev = show_idx;
        repeat (60) begin
            @(negedge clk);
            if (show_idx != prev) changes++;
            prev = show_idx;
        end
        mode_auto = 1'b0;
        check("s2_changes", 32'(changes),   32'd14);
        check("s2_idx",     32'(show_idx),  32'd1);
        check("s2_data",    show_data,      32'hA5A5_0101);

        // manual stepping up to the wrap point, with a stray rd_valid while idle
        for (int i = 0; i < 11; i++) begin
            pulse_step();
            wait_idle(20, "s3_step");
        end
        check("s3_idx12", 32'(show_idx), 32'd12);
        stray_tok++;
        repeat (3) @(negedge clk);
        check("s3_stray", show_data, 32'hA5A5_0C0C);
        pulse_step();
        wait_idle(20, "s3_wrap");
        check("s3_wrap_idx",  32'(show_idx), 32'd0);
        check("s3_wrap_data", show_data,     32'hA5A5_0000);

        // simultaneous tick and step_req
        mode_auto = 1'b1;
        repeat (4) @(negedge clk);
        pulse_step();
        mode_auto = 1'b0;
        wait_idle(20, "s3_both");
        check("s3_both_idx", 32'(show_idx), 32'd1);

        // grant withheld while three further steps arrive
        gnt_withhold = 20;
        pulse_step();
        for (int i = 0; i < 3; i++) begin
            repeat (3) @(negedge clk);
            check("s4_req_held", 32'(rd_req),  32'd1);
            check("s4_addr",     32'(rd_addr), 32'd2);
            if (i == 1) stray_tok++;
            pulse_step();
        end
        seen = 0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (!rd_req) seen = 1;
        end
        if (!seen) check("s4_grant_timeout", 32'd0, 32'd1);
        gnt_withhold = 0;
        wait_idle(30, "s4");
        repeat (5) @(negedge clk);
        check("s4_idx", 32'(show_idx), 32'd3);

        // hold pauses the period without losing the partial count
        mode_auto = 1'b1;
        repeat (2) @(negedge clk);
        hold = 1'b1;
        repeat (4) @(negedge clk);
        pulse_step();
        repeat (5) @(negedge clk);
        check("s5_hold_idx", 32'(show_idx), 32'd3);
        hold = 1'b0;
        c_rel = cyc;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (show_idx != 4'd3) begin
                seen = 1;
                mode_auto = 1'b0;
                check("s5_tick_delay", 32'(cyc - c_rel), 32'd3);
            end
        end
        mode_auto = 1'b0;
        if (!seen) check("s5_no_tick", 32'd0, 32'd1);
        wait_idle(20, "s5");
        check("s5_idx", 32'(show_idx), 32'd4);

        // reset while waiting for rd_valid
        valid_lat = 6;
        pulse_step();
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (dbg_state == WAIT) seen = 1;
            else @(negedge clk);
        end
        check("s6_in_wait", 32'(dbg_state), 32'(WAIT));
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("s6_req",   32'(rd_req),     32'd0);
        check("s6_idx",   32'(show_idx),   32'd0);
        check("s6_valid", 32'(show_valid), 32'd0);
        check("s6_data",  show_data,       32'd0);
        check("s6_addr",  32'(rd_addr),    32'd0);
        @(negedge clk);
        @(negedge clk);
        valid_lat = 1;
        rst_n = 1'b1;
        wait_idle(20, "s6");
        check("s6_refetch_idx",  32'(show_idx), 32'd0);
        check("s6_refetch_data", show_data,     32'hA5A5_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        n_fail++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
